// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the IF-stage fetch controller.
package fetch_ctrl_pkg;

  // Width of the fetch entry fields (PC and instruction word).
  localparam int FC_W = 32;

  // Sequential fetch advances by one instruction word.
  localparam int INSTR_BYTES = 4;

  // Default reset fetch address; the PC register must reset to the same value.
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0060;

  // Controller states.
  //   START   : first cycle out of reset, no cache read yet
  //   FETCH   : cache read outstanding on pc_value
  //   HOLD    : response parked in the skid buffer, waiting for decode
  //   DISCARD : redirect seen mid-read; finish the old read and drop its data
  typedef enum logic [1:0] {
    START   = 2'd0,
    FETCH   = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } fc_state_e;

  // One fetched instruction with the PC it was read from.
  typedef struct packed {
    logic [FC_W-1:0] pc;
    logic [FC_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_ctrl_skid_buf.sv
// if_skid_buf: IF/ID output slot plus a one-entry skid buffer.
// A push lands in the slot when the slot is free, otherwise in the buffer.
// A parked buffer entry moves into the slot as soon as the slot frees.
// flush invalidates both entries and wins over everything else.
module if_skid_buf
  import fetch_ctrl_pkg::*;
#(
  parameter logic [FC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  input  fetch_entry_t in_entry,
  output logic         out_valid,
  input  logic         out_ready,
  output fetch_entry_t out_entry,
  output logic         buf_valid,
  output logic         slot_free
);

  localparam fetch_entry_t RESET_ENTRY = '{pc: RESET_PC, instr: '0};

  logic         slot_vld_q, slot_vld_d;
  fetch_entry_t slot_q, slot_d;
  logic         buf_vld_q, buf_vld_d;
  fetch_entry_t buf_q, buf_d;

  // Slot can take new data if empty or being consumed this cycle.
  assign slot_free = !slot_vld_q || out_ready;

  assign out_valid = slot_vld_q;
  assign out_entry = slot_q;
  assign buf_valid = buf_vld_q;

  // Next-state for slot and buffer: flush > drain buffer > push > consume.
  always_comb begin
    slot_vld_d = slot_vld_q;
    slot_d     = slot_q;
    buf_vld_d  = buf_vld_q;
    buf_d      = buf_q;
    if (flush) begin
      slot_vld_d = 1'b0;
      buf_vld_d  = 1'b0;
    end else if (buf_vld_q) begin
      // The controller never pushes while the buffer is occupied.
      if (slot_free) begin
        slot_d     = buf_q;
        slot_vld_d = 1'b1;
        buf_vld_d  = 1'b0;
      end
    end else if (in_valid) begin
      if (slot_free) begin
        slot_d     = in_entry;
        slot_vld_d = 1'b1;
      end else begin
        buf_d     = in_entry;
        buf_vld_d = 1'b1;
      end
    end else if (out_ready) begin
      slot_vld_d = 1'b0;
    end
  end

  // Slot and buffer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_vld_q <= 1'b0;
      slot_q     <= RESET_ENTRY;
      buf_vld_q  <= 1'b0;
      buf_q      <= RESET_ENTRY;
    end else begin
      slot_vld_q <= slot_vld_d;
      slot_q     <= slot_d;
      buf_vld_q  <= buf_vld_d;
      buf_q      <= buf_d;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: IF-stage sequencer. Chooses when/what the PC register loads,
// runs the I-cache read handshake and feeds decode through a skid slot.
// Redirects from EX take priority over cache responses, which take priority
// over slot release. A redirect during an outstanding read keeps the old
// address on the cache until it responds, then loads the newest target.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pc_value,
  output logic             pc_load,
  output logic [WIDTH-1:0] pc_next,
  output logic             icache_read,
  output logic [WIDTH-1:0] icache_address,
  input  logic             icache_resp,
  input  logic [WIDTH-1:0] icache_rdata,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             if_valid,
  input  logic             if_ready,
  output logic [WIDTH-1:0] if_pc,
  output logic [WIDTH-1:0] if_instr
);

  localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(INSTR_BYTES);

  fc_state_e        state_q, state_d;
  logic [WIDTH-1:0] pending_q, pending_d;

  logic             load_c;
  logic             read_c;
  logic [WIDTH-1:0] next_c;
  logic             flush_c;
  logic             push_c;
  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] redir_tgt;

  fetch_entry_t     push_entry;
  fetch_entry_t     slot_entry;
  logic             slot_free;
  logic             buf_valid;

  // Sequential successor wraps naturally at 2^WIDTH; targets are word aligned.
  assign pc_inc    = pc_value + PC_STEP;
  assign redir_tgt = {redirect_pc[WIDTH-1:2], 2'b00};

  // The cache reads whatever the PC register holds; the FSM only changes
  // it through pc_load, and only in a cycle where the read completes or
  // no read is outstanding.
  assign icache_address = pc_value;

  assign push_entry = '{pc: FC_W'(pc_value), instr: FC_W'(icache_rdata)};

  // Strobes are forced low while reset is asserted so nothing leaks out
  // before the state register has settled.
  assign pc_load     = load_c & ~rst;
  assign icache_read = read_c & ~rst;
  assign pc_next     = next_c;

  // Next-state, PC load and slot control.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    load_c    = 1'b0;
    read_c    = 1'b0;
    next_c    = pc_inc;
    flush_c   = 1'b0;
    push_c    = 1'b0;
    case (state_q)
      START: begin
        state_d = FETCH;
        if (redirect_valid) begin
          flush_c = 1'b1;
          load_c  = 1'b1;
          next_c  = redir_tgt;
        end
      end
      FETCH: begin
        read_c = 1'b1;
        if (redirect_valid) begin
          flush_c = 1'b1;
          if (icache_resp) begin
            // Read finished this cycle: drop it and retarget immediately.
            load_c = 1'b1;
            next_c = redir_tgt;
          end else begin
            // Read still in flight: address must stay put until it answers.
            pending_d = redir_tgt;
            state_d   = DISCARD;
          end
        end else if (icache_resp) begin
          push_c = 1'b1;
          if (slot_free) begin
            load_c = 1'b1;
            next_c = pc_inc;
          end else begin
            // Data parked in the buffer; PC stays on it until it drains.
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          flush_c = 1'b1;
          load_c  = 1'b1;
          next_c  = redir_tgt;
          state_d = FETCH;
        end else if (buf_valid && slot_free) begin
          load_c  = 1'b1;
          next_c  = pc_inc;
          state_d = FETCH;
        end
      end
      DISCARD: begin
        read_c = 1'b1;
        if (redirect_valid) begin
          flush_c   = 1'b1;
          pending_d = redir_tgt;
        end
        if (icache_resp) begin
          // Newest target wins: a redirect in this very cycle beats pending.
          load_c  = 1'b1;
          next_c  = redirect_valid ? redir_tgt : pending_q;
          state_d = FETCH;
        end
      end
      default: begin
        state_d = START;
      end
    endcase
  end

  // State and pending-redirect registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= START;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

  if_skid_buf #(
    .RESET_PC (FC_W'(RESET_PC))
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush_c),
    .in_valid  (push_c),
    .in_entry  (push_entry),
    .out_valid (if_valid),
    .out_ready (if_ready),
    .out_entry (slot_entry),
    .buf_valid (buf_valid),
    .slot_free (slot_free)
  );

  assign if_pc    = WIDTH'(slot_entry.pc);
  assign if_instr = WIDTH'(slot_entry.instr);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: PC register and I-cache models, scoreboard of
// expected (pc, instr) pairs popped on every decode accept.
module tb_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] pc_value;
  logic        pc_load;
  logic [31:0] pc_next;
  logic        icache_read;
  logic [31:0] icache_address;
  logic        icache_resp;
  logic [31:0] icache_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  logic [31:0] sb_q[$];

  // cache model knobs
  int          lat;
  int          resp_limit;
  int          resp_cnt;
  logic [31:0] wait_cnt;

  fetch_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .pc_value       (pc_value),
    .pc_load        (pc_load),
    .pc_next        (pc_next),
    .icache_read    (icache_read),
    .icache_address (icache_address),
    .icache_resp    (icache_resp),
    .icache_rdata   (icache_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // PC register
  always @(posedge clk or posedge rst) begin
    if (rst) pc_value <= 32'h0000_0060;
    else if (pc_load) pc_value <= pc_next;
  end

  // I-cache: answers after `lat` waiting cycles, at most resp_limit times
  assign icache_resp  = icache_read && (wait_cnt >= 32'(lat)) && (resp_cnt < resp_limit);
  assign icache_rdata = instr_of(icache_address);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
      resp_cnt <= 0;
    end else if (icache_resp) begin
      wait_cnt <= '0;
      resp_cnt <= resp_cnt + 1;
    end else if (icache_read) begin
      wait_cnt <= wait_cnt + 1;
    end
  end

  // Scoreboard pop on accept, plus address-stability check on open reads
  logic        prev_open;
  logic [31:0] prev_addr;
  initial begin
    prev_open = 1'b0;
    prev_addr = '0;
  end
  always @(negedge clk) begin
    if (!rst && if_valid && if_ready) begin
      if (sb_q.size() == 0) begin
        chk("sb_extra", sb_q.size(), 1);
      end else begin
        logic [31:0] e;
        e = sb_q.pop_front();
        chk("if_pc", if_pc, e);
        chk("if_instr", if_instr, instr_of(e));
      end
    end
    if (!rst && prev_open && icache_read) chk("addr_stable", icache_address, prev_addr);
    prev_open = !rst && icache_read && !icache_resp;
    prev_addr = icache_address;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 time unit into the START cycle.
  task automatic do_reset();
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_if_valid", {31'd0, if_valid}, 0);
    chk("rst_if_pc", if_pc, 32'h60);
    chk("rst_if_instr", if_instr, 0);
    chk("rst_read", {31'd0, icache_read}, 0);
    chk("rst_pc_load", {31'd0, pc_load}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic chk_sb_empty(input string tag);
    chk(tag, sb_q.size(), 0);
    sb_q.delete();
  endtask

  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; if_ready = 1'b0;
    lat = 0; resp_limit = 0;

    // T1: steady fetch
    lat = 0; resp_limit = 3; if_ready = 1'b1;
    sb_q.push_back(32'h60); sb_q.push_back(32'h64); sb_q.push_back(32'h68);
    do_reset();
    #2 chk("t1_start_read", {31'd0, icache_read}, 0);
    tick(); #2;
    chk("t1_read", {31'd0, icache_read}, 1);
    chk("t1_addr", icache_address, 32'h60);
    chk("t1_load", {31'd0, pc_load}, 1);
    chk("t1_next", pc_next, 32'h64);
    tick(); #2;
    chk("t1_addr2", icache_address, 32'h64);
    chk("t1_load2", {31'd0, pc_load}, 1);
    repeat (6) tick();
    chk("t1_addr_end", icache_address, 32'h6C);
    chk_sb_empty("t1_sb_empty");

    // T2: back-pressure into HOLD
    lat = 0; resp_limit = 3; if_ready = 1'b0;
    sb_q.push_back(32'h60); sb_q.push_back(32'h64); sb_q.push_back(32'h68);
    do_reset();
    tick(); #2 chk("t2_next", pc_next, 32'h64);
    tick(); #2;
    chk("t2_valid", {31'd0, if_valid}, 1);
    chk("t2_addr", icache_address, 32'h64);
    chk("t2_noload", {31'd0, pc_load}, 0);
    tick(); #2;
    chk("t2_hold_read", {31'd0, icache_read}, 0);
    chk("t2_hold_pc", if_pc, 32'h60);
    tick(); #2 chk("t2_hold_read2", {31'd0, icache_read}, 0);
    tick(); if_ready = 1'b1; #2;
    chk("t2_rel_load", {31'd0, pc_load}, 1);
    chk("t2_rel_next", pc_next, 32'h68);
    tick(); #2;
    chk("t2_buf_pc", if_pc, 32'h64);
    chk("t2_resume_addr", icache_address, 32'h68);
    repeat (5) tick();
    chk_sb_empty("t2_sb_empty");

    // T3: redirect with same-cycle response
    lat = 0; resp_limit = 4; if_ready = 1'b1;
    sb_q.push_back(32'h60); sb_q.push_back(32'h200); sb_q.push_back(32'h204);
    do_reset();
    tick();
    tick(); redirect_valid = 1'b1; redirect_pc = 32'h200; #2;
    chk("t3_load", {31'd0, pc_load}, 1);
    chk("t3_next", pc_next, 32'h200);
    tick(); redirect_valid = 1'b0; #2;
    chk("t3_flush", {31'd0, if_valid}, 0);
    chk("t3_addr", icache_address, 32'h200);
    tick(); #2 chk("t3_pc", if_pc, 32'h200);
    repeat (4) tick();
    chk_sb_empty("t3_sb_empty");

    // T4: redirect during miss, then newer redirect in DISCARD
    lat = 4; resp_limit = 2; if_ready = 1'b1;
    sb_q.push_back(32'h300);
    do_reset();
    tick(); #2 chk("t4_addr", icache_address, 32'h60);
    tick(); redirect_valid = 1'b1; redirect_pc = 32'h100; #2;
    chk("t4_noload", {31'd0, pc_load}, 0);
    tick(); redirect_valid = 1'b0; #2;
    chk("t4_disc_read", {31'd0, icache_read}, 1);
    chk("t4_disc_addr", icache_address, 32'h60);
    tick(); redirect_valid = 1'b1; redirect_pc = 32'h300; #2;
    chk("t4_noload2", {31'd0, pc_load}, 0);
    tick(); redirect_valid = 1'b0; #2;
    chk("t4_resp", {31'd0, icache_resp}, 1);
    chk("t4_load", {31'd0, pc_load}, 1);
    chk("t4_next", pc_next, 32'h300);
    tick(); #2;
    chk("t4_addr_new", icache_address, 32'h300);
    chk("t4_drop", {31'd0, if_valid}, 0);
    repeat (8) tick();
    chk_sb_empty("t4_sb_empty");

    // T5: wrap and alignment
    lat = 0; resp_limit = 4; if_ready = 1'b1;
    sb_q.push_back(32'hFFFF_FFFC); sb_q.push_back(32'h120);
    do_reset();
    tick(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; #2;
    chk("t5_next_top", pc_next, 32'hFFFF_FFFC);
    tick(); redirect_valid = 1'b0; #2;
    chk("t5_addr_top", icache_address, 32'hFFFF_FFFC);
    chk("t5_wrap", pc_next, 32'h0);
    tick(); redirect_valid = 1'b1; redirect_pc = 32'h123; #2;
    chk("t5_addr0", icache_address, 32'h0);
    chk("t5_align", pc_next, 32'h120);
    tick(); redirect_valid = 1'b0; #2;
    chk("t5_addr_al", icache_address, 32'h120);
    repeat (4) tick();
    chk_sb_empty("t5_sb_empty");

    // T6: async reset mid-HOLD
    lat = 0; resp_limit = 5; if_ready = 1'b0;
    do_reset();
    tick(); tick(); tick(); #2;
    chk("t6_hold_read", {31'd0, icache_read}, 0);
    chk("t6_hold_valid", {31'd0, if_valid}, 1);
    #1 rst = 1'b1;
    #1;
    chk("t6_rst_valid", {31'd0, if_valid}, 0);
    chk("t6_rst_read", {31'd0, icache_read}, 0);
    chk("t6_rst_load", {31'd0, pc_load}, 0);
    chk("t6_rst_pc", if_pc, 32'h60);
    resp_limit = 2; if_ready = 1'b1;
    sb_q.push_back(32'h60); sb_q.push_back(32'h64);
    @(posedge clk);
    #1 rst = 1'b0;
    tick(); #2;
    chk("t6_restart_read", {31'd0, icache_read}, 1);
    chk("t6_restart_addr", icache_address, 32'h60);
    repeat (5) tick();
    chk_sb_empty("t6_sb_empty");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequences the IF stage: decides when the PC register loads and what it loads, drives the instruction-cache read handshake, and presents fetched instructions to decode through a valid/ready slot.
- Handles back-pressure from decode with a one-entry buffer.
- Handles branch/jump redirects from EX, including redirects that arrive while a cache read is in flight.
- Sits between the PC register, the I-cache and the IF/ID boundary.

Parameters:
- WIDTH, 32, address/data width.
- RESET_PC, 32'h00000060, reset fetch address; must equal the PC register reset value.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- pc_value  in  WIDTH  current PC register output
- pc_load  out  1  load strobe to PC register
- pc_next  out  WIDTH  value loaded into PC when pc_load=1
- icache_read  out  1  read request
- icache_address  out  WIDTH  read address, equal to pc_value
- icache_resp  in  1  read complete; icache_rdata valid this cycle
- icache_rdata  in  WIDTH  instruction word
- redirect_valid  in  1  one-cycle redirect pulse from EX
- redirect_pc  in  WIDTH  redirect target
- if_valid  out  1  fetched-instruction slot valid
- if_ready  in  1  decode accepts slot this cycle
- if_pc  out  WIDTH  PC of slot instruction
- if_instr  out  WIDTH  slot instruction

Behaviour:
- Reset: state=START; if_valid=0; if_pc=RESET_PC; if_instr=0; buffer invalid; pending=0.
- Combinational outputs: pc_load=0 and icache_read=0 whenever rst=1.
- The slot is free when !if_valid || if_ready. An accept (if_valid && if_ready) clears if_valid next cycle unless the slot is refilled in the same cycle.
- Cache protocol:
  - icache_read is held high with a stable address until icache_resp is sampled high.
  - Response may come in the same cycle as the read or any later cycle.
  - The address may change only in the cycle after a resp.
  - icache_read may stay high back-to-back.
- pc_next arithmetic: pc_value+4, modulo 2^WIDTH (0xFFFFFFFC+4 wraps to 0). Redirect targets have bits [1:0] forced to 0.
- States:
  - START: read=0. Next cycle goes to FETCH. A redirect here gives pc_load=1, pc_next=redirect_pc, then FETCH.
  - FETCH: read=1.
    - Redirect, any resp value:
      - with resp=1: drop the data, clear the slot, pc_load redirect_pc, stay FETCH.
      - with resp=0: clear the slot, latch pending=redirect_pc, go to DISCARD.
    - resp with slot free: slot<={1, pc_value, rdata}; pc_load pc+4; stay FETCH.
    - resp with slot full: buf<={pc_value, rdata}; no load; go to HOLD.
    - no resp: hold.
  - HOLD: read=0.
    - Redirect: clear slot and buf, pc_load redirect_pc, go to FETCH.
    - Slot frees: slot<=buf; pc_load pc+4; go to FETCH.
    - Otherwise: hold.
  - DISCARD: read=1 on the old address.
    - A redirect overwrites pending (newest wins).
    - On resp: data dropped; pc_load=1 with pc_next = newest target (a same-cycle redirect beats pending); go to FETCH.
- Priority: redirect > resp > slot release.
- Slot on redirect: if_valid=0 the next cycle regardless of if_ready.
- Latency:
  - Resp at cycle t puts if_valid=1 at t+1.
  - The next read address appears at t+1 via the PC register.
  - A redirect in FETCH with resp=1 gives the new address at t+1.
- Reset mid-operation: all state returns to START immediately, and any in-flight cache read is abandoned. The cache is reset by the same rst.
- No outputs are X after reset. Illegal state encodings recover to START.

Decomposition:
- fetch_ctrl_pkg holds:
  - the state enum fc_state_e {START, FETCH, HOLD, DISCARD};
  - the constants INSTR_BYTES=4 and RESET_PC_DEFAULT=32'h60;
  - the struct fetch_entry_t {pc, instr}, used for both slot and buffer.
- The slot plus one-entry buffer is a natural sub-module: if_skid_buf, a 1-entry skid with valid/ready and a flush input. The FSM stays in fetch_ctrl.

Test Plan:
- Reset then steady fetch, resp every cycle, if_ready=1 -> read starts at 0x60; if_pc sequence 0x60, 0x64, 0x68 with matching rdata; pc_load=1 each resp cycle.
- Back-pressure: if_ready=0 for 3 cycles after the first instruction -> second resp captured in buf, read=0 in HOLD; on release, if_pc 0x64 is presented the next cycle and fetch resumes at 0x68 with no loss or duplication.
- Redirect with resp in the same cycle, target 0x200 -> that rdata is dropped; if_valid=0 next cycle; pc_next=0x200; the next presented if_pc=0x200.
- Redirect at 0x100 while a miss is pending (resp 4 cycles later), then a second redirect to 0x300 during DISCARD -> read stays on the old address until resp; data is dropped; the PC loads 0x300, not 0x100.
- Wrap and alignment: pc 0xFFFFFFFC -> pc_next 0x00000000; redirect_pc 0x123 -> loads 0x120.
- Async reset asserted mid-HOLD between clock edges -> if_valid and icache_read go 0 immediately; fetch restarts at 0x60.
